// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the sequential 8x8 shift-and-add multiplier.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;
  localparam int ITER   = 8;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Existing 8-bit carry-lookahead adder (carry-in tied low), reused by the multiplier.
module carry_lookahead_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s    = p ^ c[7:0];
    cout = c[8];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier with start/busy/done handshake.
// Optional early termination when the remaining multiplier bits are zero: SHIFT_ADD_MULT_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one add/shift iteration per cycle
// DONE  | product valid, done high for this cycle; start here is accepted back-to-back
module shift_add_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  generate
    if (WIDTH != MUL_W) begin : g_bad_width
      $error("shift_add_multiplier: only WIDTH=8 is supported");
    end
    if ((2 ** CNT_W) <= ITER) begin : g_bad_cnt_w
      $error("shift_add_multiplier: CNT_W too narrow to hold WIDTH");
    end
  endgenerate

  state_t            state, state_nxt;
  logic [MUL_W-1:0]  m_q, a_q, q_q;
  logic              c_q;
  logic [CNT_W-1:0]  cnt, cnt_inc, shamt;
  logic [MUL_W-1:0]  addend, sum;
  logic              cout;
  logic [PROD_W:0]   acc, shift_val;
  logic [PROD_W-1:0] early_val;
  logic              last_iter, early_term, load;

  carry_lookahead_adder u_cla (
    .a    (a_q),
    .b    (addend),
    .s    (sum),
    .cout (cout)
  );

  always_comb begin
    addend    = q_q[0] ? m_q : '0;
    acc       = {c_q, a_q, q_q};
    // cout lands in bit 16 before the shift, so it ends up in A[7]
    shift_val = {cout, sum, q_q} >> 1;
    cnt_inc   = cnt + 1'b1;
    shamt     = CNT_W'(ITER) - cnt;
    early_val = PROD_W'(acc >> shamt);
    last_iter = (cnt_inc == CNT_W'(ITER));
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    early_term = ((q_q & ({MUL_W{1'b1}} >> cnt)) == '0);
`else
    early_term = 1'b0;
`endif
    load      = start && ((state == IDLE) || (state == DONE));

    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (early_term || last_iter) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (load) begin
      m_q <= a;
      q_q <= b;
      a_q <= '0;
      c_q <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      if (early_term) begin
        product <= early_val;
      end else begin
        {c_q, a_q, q_q} <= shift_val;
        cnt             <= cnt_inc;
        if (last_iter) product <= shift_val[PROD_W-1:0];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier against an arithmetic reference.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference latency in edges from acceptance to done
  function automatic int ref_lat(input logic [7:0] bv);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    int msb;
    if (bv == 0) return 1;
    msb = 0;
    for (int i = 0; i < 8; i++) if (bv[i]) msb = i;
    return (msb + 2 > 8) ? 8 : msb + 2;
`else
    return 8;
`endif
  endfunction

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the accepting edge; returns edges until done and busy cycle count.
  task automatic wait_done(output int n, output int busy_n);
    n      = 0;
    busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("done_timeout", 32'(n), 32'(0));
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv);
    int n, bn;
    logic [15:0] prev;
    prev = product;
    start_op(av, bv);
    check({tag, "_hold"}, product, prev);
    wait_done(n, bn);
    check({tag, "_lat"}, 32'(n), 32'(ref_lat(bv)));
    check({tag, "_busy"}, 32'(bn), 32'(ref_lat(bv)));
    check({tag, "_prod"}, product, 32'(av) * 32'(bv));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bn, pulses;
    logic [7:0] ra, rb;

    #23;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("d13x11", 8'd13, 8'd11);
    check("d13x11_val", product, 16'h008F);
    run_op("ffxff", 8'hFF, 8'hFF);
    check("ffxff_val", product, 16'hFE01);
    run_op("zero_a", 8'h00, 8'hA5);
    run_op("zero_b", 8'h7B, 8'h00);

    // Start while busy is ignored; then back-to-back start in the DONE cycle
    start_op(8'd2, 8'd2);
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    a = 8'd3;
    b = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (done) pulses++;
    wait_done(n, bn);
    check("ign_prod", product, 16'h0004);
    start = 1'b1;
    a = 8'd3;
    b = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_hold", product, 16'h0004);
    wait_done(n, bn);
    check("b2b_lat", 32'(n), 32'(ref_lat(8'd5)));
    check("b2b_prod", product, 16'h000F);
    check("ign_pulses", 32'(pulses), 0);
    @(posedge clk);
    #1;
    check("b2b_pulse", done, 0);

    // Async reset mid-operation
    start_op(8'd200, 8'd100);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_prod", product, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    check("arst_quiet", 32'(pulses), 0);
    run_op("after_rst", 8'd200, 8'd100);
    check("after_rst_val", product, 16'h4E20);

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 6 == 0) rb = 8'(1 << (i % 8));
      run_op("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
